// File: rtl/uart_loader.sv
// UART program loader: decodes L/R/H command bytes, writes little-endian words to IMEM, gates CPU run.
// Pops at most one RX byte per 2 cycles; responses wait in TX until the TX FIFO has room.

module uart_loader #(
   parameter int NB_INSTRUCTION  = 32,
   parameter int IMEM_ADDR_WIDTH = 10,
   parameter int NB_UART_DATA    = 8,
   parameter int NB_TIMEOUT      = 24,
   parameter int TIMEOUT_CYCLES  = 10_000_000
) (
   input  logic                       clk,
   input  logic                       i_rst,
   input  logic [NB_UART_DATA-1:0]    i_uart_rx_data,
   input  logic                       i_uart_rx_empty,
   output logic                       o_uart_rd,
   input  logic                       i_uart_tx_full,
   output logic                       o_uart_wr,
   output logic [NB_UART_DATA-1:0]    o_uart_wdata,
   output logic                       o_uart_tx_start,
   output logic                       o_imem_we,
   output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
   output logic [NB_INSTRUCTION-1:0]  o_imem_wdata,
   output logic                       o_cpu_en
);

   localparam int BPW       = NB_INSTRUCTION / NB_UART_DATA;
   localparam int NB_BCNT   = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int MAX_WORDS = 1 << IMEM_ADDR_WIDTH;

   localparam logic [NB_UART_DATA-1:0] BYTE_ACK  = NB_UART_DATA'(8'h06);
   localparam logic [NB_UART_DATA-1:0] BYTE_NAK  = NB_UART_DATA'(8'h15);
   localparam logic [NB_UART_DATA-1:0] CMD_LOAD  = NB_UART_DATA'(8'h4C);
   localparam logic [NB_UART_DATA-1:0] CMD_RUN   = NB_UART_DATA'(8'h52);
   localparam logic [NB_UART_DATA-1:0] CMD_HALT  = NB_UART_DATA'(8'h48);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_CNT_LO, S_CNT_HI, S_BYTE, S_WRITE, S_TX
   } state_t;

   state_t                     r_state;
   state_t                     w_state_next;
   logic [NB_UART_DATA-1:0]    w_resp;
   logic [NB_UART_DATA-1:0]    r_byte;
   logic [NB_UART_DATA-1:0]    r_cnt_lo;
   logic [NB_UART_DATA-1:0]    r_tx_byte;
   logic [NB_INSTRUCTION-1:0]  r_shift;
   logic [IMEM_ADDR_WIDTH:0]   r_widx;
   logic [IMEM_ADDR_WIDTH:0]   r_nwords;
   logic [NB_BCNT-1:0]         r_bcnt;
   logic [NB_TIMEOUT-1:0]      r_to;
   logic                       r_rd_q;
   logic                       r_tx_start;
   logic                       r_cpu_en;
   logic                       w_consume;
   logic                       w_pop;
   logic                       w_to_tick;
   logic                       w_to_abort;
   logic [31:0]                w_n;

   // A popped byte is acted on the cycle after the pop, which also spaces pops two cycles apart.
   assign w_consume  = (r_state == S_IDLE) || (r_state == S_CNT_LO) ||
                       (r_state == S_CNT_HI) || (r_state == S_BYTE);
   assign w_pop      = !i_rst && !i_uart_rx_empty && !r_rd_q && w_consume;
   assign w_to_tick  = w_consume && (r_state != S_IDLE) && i_uart_rx_empty && !r_rd_q;
   assign w_to_abort = w_to_tick && (r_to == NB_TIMEOUT'(TIMEOUT_CYCLES - 1));
   assign w_n        = 32'({r_byte, r_cnt_lo});

   always_ff @(posedge clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_resp       = BYTE_ACK;
      case (r_state)
         S_IDLE: if (w_pop) w_state_next = S_CMD;
         S_CMD: begin
            if (r_byte == CMD_LOAD) begin
               w_state_next = S_CNT_LO;
            end else begin
               w_state_next = S_TX;
               if (r_byte != CMD_RUN && r_byte != CMD_HALT) w_resp = BYTE_NAK;
            end
         end
         S_CNT_LO: begin
            if (w_to_abort) begin
               w_state_next = S_TX;
               w_resp       = BYTE_NAK;
            end else if (r_rd_q) begin
               w_state_next = S_CNT_HI;
            end
         end
         S_CNT_HI: begin
            if (w_to_abort) begin
               w_state_next = S_TX;
               w_resp       = BYTE_NAK;
            end else if (r_rd_q) begin
               if (w_n > 32'(MAX_WORDS)) begin
                  w_state_next = S_TX;
                  w_resp       = BYTE_NAK;
               end else if (w_n == 32'd0) begin
                  w_state_next = S_TX;
               end else begin
                  w_state_next = S_BYTE;
               end
            end
         end
         S_BYTE: begin
            if (w_to_abort) begin
               w_state_next = S_TX;
               w_resp       = BYTE_NAK;
            end else if (r_rd_q && r_bcnt == NB_BCNT'(BPW - 1)) begin
               w_state_next = S_WRITE;
            end
         end
         S_WRITE: w_state_next = (r_widx == r_nwords - 1'b1) ? S_TX : S_BYTE;
         S_TX:    if (!i_uart_tx_full) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_uart_rd    = w_pop;
      o_uart_wr    = 1'b0;
      o_imem_we    = 1'b0;
      o_imem_addr  = '0;
      o_imem_wdata = '0;
      case (r_state)
         S_TX:    o_uart_wr = !i_uart_tx_full;
         S_WRITE: begin
            o_imem_we    = 1'b1;
            o_imem_addr  = r_widx[IMEM_ADDR_WIDTH-1:0];
            o_imem_wdata = r_shift;
         end
         default: ;
      endcase
   end

   assign o_uart_wdata    = r_tx_byte;
   assign o_uart_tx_start = r_tx_start;
   assign o_cpu_en        = r_cpu_en;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_byte     <= '0;
         r_cnt_lo   <= '0;
         r_tx_byte  <= '0;
         r_shift    <= '0;
         r_widx     <= '0;
         r_nwords   <= '0;
         r_bcnt     <= '0;
         r_to       <= '0;
         r_rd_q     <= 1'b0;
         r_tx_start <= 1'b0;
         r_cpu_en   <= 1'b0;
      end else begin
         r_rd_q     <= w_pop;
         r_tx_start <= o_uart_wr;
         if (w_pop) r_byte <= i_uart_rx_data;
         if (w_pop || r_state == S_TX) r_to <= '0;
         else if (w_to_tick)           r_to <= r_to + 1'b1;
         if (r_state == S_CMD) begin
            if (r_byte == CMD_LOAD || r_byte == CMD_HALT) r_cpu_en <= 1'b0;
            else if (r_byte == CMD_RUN)                   r_cpu_en <= 1'b1;
         end
         if (r_state == S_CNT_LO && r_rd_q) r_cnt_lo <= r_byte;
         if (r_state == S_CNT_HI && r_rd_q) begin
            r_nwords <= w_n[IMEM_ADDR_WIDTH:0];
            r_widx   <= '0;
            r_bcnt   <= '0;
         end
         if (r_state == S_BYTE && r_rd_q) begin
            r_shift <= {r_byte, r_shift[NB_INSTRUCTION-1:NB_UART_DATA]};
            r_bcnt  <= (r_bcnt == NB_BCNT'(BPW - 1)) ? '0 : r_bcnt + 1'b1;
         end
         if (r_state == S_WRITE) r_widx <= r_widx + 1'b1;
         if (w_state_next == S_TX && r_state != S_TX) r_tx_byte <= w_resp;
      end
   end

endmodule
